// File: rtl/frame_addr_pkg.sv
// Shared types and defaults for the frame-buffer read address generator.
// Imported by the interface, bank controller and top level.
package frame_addr_pkg;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int DEF_H_ACT  = 320;
  localparam int DEF_V_ACT  = 240;
  localparam int DEF_BANKS  = 2;
  localparam int DEF_ADDR_W = 18;

  localparam logic MODE_1X = 1'b0;
  localparam logic MODE_2X = 1'b1;

  function automatic int bank_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_addr_if.sv
// Timing-side strobes in, RAM read address and status out.
// master = timing generator side, slave = address generator.
interface frame_addr_if
  import frame_addr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BANK_W = 1
);

  logic              enable;
  logic              vsync;
  logic              scale_2x;
  logic              swap_req;
  logic [ADDR_W-1:0] address;
  logic              addr_valid;
  logic              frame_done;
  logic [BANK_W-1:0] active_bank;
  logic              swap_ack;

  modport master (
    output enable, vsync, scale_2x, swap_req,
    input  address, addr_valid, frame_done,
    input  active_bank, swap_ack
  );

  modport slave (
    input  enable, vsync, scale_2x, swap_req,
    output address, addr_valid, frame_done,
    output active_bank, swap_ack
  );

endinterface

// File: rtl/frame_addr_gen_bank_ctrl.sv
// Vsync edge detect and double-buffer bank swap handshake.
// Bank base is stepped by one frame size; no multiplier.
module fb_bank_ctrl
  import frame_addr_pkg::*;
#(
  parameter int NUM_BANKS = DEF_BANKS,
  parameter int FRAME_SZ  = DEF_H_ACT * DEF_V_ACT,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BANK_W    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vsync,
  input  logic              swap_req,
  output logic              vs_fall,
  output logic              swap_ack,
  output logic [BANK_W-1:0] bank,
  output logic [ADDR_W-1:0] base_nxt
);

  localparam bit MULTI = NUM_BANKS > 1;
  localparam logic [BANK_W-1:0] LAST_BANK =
    BANK_W'(NUM_BANKS - 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(FRAME_SZ);

  logic              vsync_d;
  logic              pending;
  logic              do_swap;
  logic [ADDR_W-1:0] base;

  assign vs_fall = vsync_d & ~vsync;
  assign do_swap = MULTI && vs_fall
                   && (pending || swap_req);

  // Next base is exported so loads in the swap cycle
  // already see the new bank.
  always_comb begin
    base_nxt = base;
    if (do_swap) begin
      base_nxt = (bank == LAST_BANK) ? '0 : base + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_d  <= 1'b0;
      pending  <= 1'b0;
      swap_ack <= 1'b0;
      bank     <= '0;
      base     <= '0;
    end else begin
      vsync_d  <= vsync;
      swap_ack <= do_swap;
      base     <= base_nxt;
      if (do_swap) begin
        bank    <= (bank == LAST_BANK) ? '0 : bank + 1'b1;
        pending <= 1'b0;
      end else if (MULTI && swap_req) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_addr_gen.sv
// Frame-buffer read address generator with 2x replication
// and vsync-aligned bank switching.
module frame_addr_gen
  import frame_addr_pkg::*;
#(
  parameter int H_ACT     = DEF_H_ACT,
  parameter int V_ACT     = DEF_V_ACT,
  parameter int NUM_BANKS = DEF_BANKS,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic          CLK25,
  input  logic          rst_n,
  frame_addr_if.slave   bus
);

  localparam int BANK_W   = bank_w(NUM_BANKS);
  localparam int FRAME_SZ = H_ACT * V_ACT;
  localparam int XW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int YW = (V_ACT > 1) ? $clog2(V_ACT) : 1;

  if (longint'(NUM_BANKS) * H_ACT * V_ACT
      > (longint'(1) << ADDR_W)) begin : g_size_chk
    $error("frame_addr_gen: ADDR_W too small");
  end

  state_t            state;
  state_t            state_n;
  logic              mode;
  logic [XW-1:0]     x;
  logic [XW-1:0]     x_n;
  logic [YW-1:0]     y;
  logic [YW-1:0]     y_n;
  logic              x_sub;
  logic              x_sub_n;
  logic              y_sub;
  logic              y_sub_n;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] line_base_n;
  logic [ADDR_W-1:0] base_nxt;
  logic [ADDR_W-1:0] address;
  logic              frame_done;
  logic              vs_fall;
  logic              swap_ack;
  logic [BANK_W-1:0] bank;

  logic consume;
  logic x_end;
  logic y_end;
  logic step_x;
  logic line_end;
  logic adv_line;
  logic last;

  fb_bank_ctrl #(
    .NUM_BANKS (NUM_BANKS),
    .FRAME_SZ  (FRAME_SZ),
    .ADDR_W    (ADDR_W),
    .BANK_W    (BANK_W)
  ) u_bank (
    .clk      (CLK25),
    .rst_n    (rst_n),
    .vsync    (bus.vsync),
    .swap_req (bus.swap_req),
    .vs_fall  (vs_fall),
    .swap_ack (swap_ack),
    .bank     (bank),
    .base_nxt (base_nxt)
  );

  assign bus.address     = address;
  assign bus.addr_valid  = (state == RUN);
  assign bus.frame_done  = frame_done;
  assign bus.active_bank = bank;
  assign bus.swap_ack    = swap_ack;

  // In 2x, x moves on odd sub-pixels; a line is replayed
  // once before the line base steps.
  always_comb begin
    consume  = (state == RUN) && bus.vsync && bus.enable;
    x_end    = (x == XW'(H_ACT - 1));
    y_end    = (y == YW'(V_ACT - 1));
    step_x   = (mode == MODE_1X) || x_sub;
    line_end = x_end && step_x;
    adv_line = line_end && ((mode == MODE_1X) || y_sub);
    last     = consume && adv_line && y_end;

    x_n = x;
    if (step_x) begin
      x_n = x_end ? '0 : x + 1'b1;
    end
    x_sub_n = (mode == MODE_2X) && !x_sub;
    y_sub_n = y_sub;
    if (line_end && (mode == MODE_2X)) begin
      y_sub_n = !y_sub;
    end
    y_n         = adv_line ? y + 1'b1 : y;
    line_base_n = line_base;
    if (adv_line) begin
      line_base_n = line_base + ADDR_W'(H_ACT);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      WAIT_VS: if (bus.vsync) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = DONE;
      default: state_n = WAIT_VS;
    endcase
    if (!bus.vsync) begin
      state_n = WAIT_VS;
    end
  end

  always_ff @(posedge CLK25) begin
    if (!rst_n) begin
      state <= WAIT_VS;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge CLK25) begin
    if (!rst_n) begin
      mode       <= MODE_1X;
      x          <= '0;
      y          <= '0;
      x_sub      <= 1'b0;
      y_sub      <= 1'b0;
      line_base  <= '0;
      address    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last;
      if (vs_fall) begin
        mode <= bus.scale_2x;
      end
      unique case (1'b1)
        (!bus.vsync || state == WAIT_VS): begin
          x         <= '0;
          y         <= '0;
          x_sub     <= 1'b0;
          y_sub     <= 1'b0;
          line_base <= '0;
          address   <= base_nxt;
        end
        (consume && !last): begin
          x         <= x_n;
          y         <= y_n;
          x_sub     <= x_sub_n;
          y_sub     <= y_sub_n;
          line_base <= line_base_n;
          address   <= base_nxt + line_base_n
                       + ADDR_W'(x_n);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_addr_gen.sv
// Self-checking bench: three configurations against a
// frame-counting reference model plus literal checkpoints.
module tb_frame_addr_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  logic en[3];
  logic vs[3];
  logic sc[3];
  logic sr[3];

  logic [31:0] o_addr[3];
  logic [31:0] o_bank[3];
  logic        o_val[3];
  logic        o_fd[3];
  logic        o_ack[3];

  frame_addr_if #(.ADDR_W(18), .BANK_W(1)) bus0 ();
  frame_addr_if #(.ADDR_W(3),  .BANK_W(1)) bus1 ();
  frame_addr_if #(.ADDR_W(6),  .BANK_W(2)) bus2 ();

  frame_addr_gen #(
    .H_ACT(320), .V_ACT(240), .NUM_BANKS(2), .ADDR_W(18)
  ) dut0 (.CLK25(clk), .rst_n(rst_n), .bus(bus0));

  frame_addr_gen #(
    .H_ACT(4), .V_ACT(2), .NUM_BANKS(1), .ADDR_W(3)
  ) dut1 (.CLK25(clk), .rst_n(rst_n), .bus(bus1));

  frame_addr_gen #(
    .H_ACT(5), .V_ACT(3), .NUM_BANKS(3), .ADDR_W(6)
  ) dut2 (.CLK25(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.enable = en[0];
  assign bus0.vsync = vs[0];
  assign bus0.scale_2x = sc[0];
  assign bus0.swap_req = sr[0];
  assign bus1.enable = en[1];
  assign bus1.vsync = vs[1];
  assign bus1.scale_2x = sc[1];
  assign bus1.swap_req = sr[1];
  assign bus2.enable = en[2];
  assign bus2.vsync = vs[2];
  assign bus2.scale_2x = sc[2];
  assign bus2.swap_req = sr[2];

  assign o_addr[0] = 32'(bus0.address);
  assign o_addr[1] = 32'(bus1.address);
  assign o_addr[2] = 32'(bus2.address);
  assign o_bank[0] = 32'(bus0.active_bank);
  assign o_bank[1] = 32'(bus1.active_bank);
  assign o_bank[2] = 32'(bus2.active_bank);
  assign o_val[0] = bus0.addr_valid;
  assign o_val[1] = bus1.addr_valid;
  assign o_val[2] = bus2.addr_valid;
  assign o_fd[0] = bus0.frame_done;
  assign o_fd[1] = bus1.frame_done;
  assign o_fd[2] = bus2.frame_done;
  assign o_ack[0] = bus0.swap_ack;
  assign o_ack[1] = bus1.swap_ack;
  assign o_ack[2] = bus2.swap_ack;

  int checks = 0;
  int failures = 0;

  // Model: pixels consumed this frame, plus phase flags.
  int hh[3] = '{320, 4, 5};
  int vv[3] = '{240, 2, 3};
  int nb[3] = '{2, 1, 3};
  int m_cnt[3];
  int m_bank[3];
  bit m_run[3];
  bit m_fin[3];
  bit m_mode[3];
  bit m_pend[3];
  bit m_ack[3];
  bit m_fd[3];
  bit m_vsd[3];
  bit started = 1'b0;

  function automatic int total(input int i);
    return hh[i] * vv[i] * (m_mode[i] ? 4 : 1);
  endfunction

  function automatic int exp_addr(input int i);
    int base;
    int k;
    base = m_bank[i] * hh[i] * vv[i];
    if (!m_run[i] && !m_fin[i]) return base;
    k = m_fin[i] ? total(i) - 1 : m_cnt[i];
    if (!m_mode[i]) return base + k;
    return base + (k / (4 * hh[i])) * hh[i]
           + (k % (2 * hh[i])) / 2;
  endfunction

  task automatic model_step(input int i);
    bit fall;
    if (!rst_n) begin
      m_cnt[i] = 0;
      m_bank[i] = 0;
      m_run[i] = 0;
      m_fin[i] = 0;
      m_mode[i] = 0;
      m_pend[i] = 0;
      m_ack[i] = 0;
      m_fd[i] = 0;
      m_vsd[i] = 0;
      return;
    end
    fall = m_vsd[i] && !vs[i];
    m_ack[i] = 0;
    m_fd[i] = 0;
    if (fall) begin
      m_mode[i] = sc[i];
      if ((m_pend[i] || sr[i]) && nb[i] > 1) begin
        m_bank[i] = (m_bank[i] + 1) % nb[i];
        m_ack[i] = 1;
        m_pend[i] = 0;
      end
    end else if (sr[i] && nb[i] > 1) begin
      m_pend[i] = 1;
    end
    if (!vs[i]) begin
      m_run[i] = 0;
      m_fin[i] = 0;
      m_cnt[i] = 0;
    end else if (!m_run[i] && !m_fin[i]) begin
      m_run[i] = 1;
      m_cnt[i] = 0;
    end else if (m_run[i] && en[i]) begin
      if (m_cnt[i] + 1 == total(i)) begin
        m_run[i] = 0;
        m_fin[i] = 1;
        m_fd[i] = 1;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
    m_vsd[i] = vs[i];
  endtask

  task automatic cmp(input string nm, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, req, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i);
      started = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int i = 0; i < 3; i++) begin
          cmp($sformatf("addr[%0d]", i),
              int'(o_addr[i]), exp_addr(i));
          cmp($sformatf("valid[%0d]", i),
              int'(o_val[i]), int'(m_run[i]));
          cmp($sformatf("done[%0d]", i),
              int'(o_fd[i]), int'(m_fd[i]));
          cmp($sformatf("bank[%0d]", i),
              int'(o_bank[i]), m_bank[i]);
          cmp($sformatf("ack[%0d]", i),
              int'(o_ack[i]), int'(m_ack[i]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_en(input int i, input int n);
    en[i] = 1'b1;
    repeat (n) tick();
    en[i] = 1'b0;
  endtask

  task automatic run_gap(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      en[i] = k[0];
      tick();
    end
    en[i] = 1'b0;
  endtask

  task automatic frame_start(input int i, input logic s);
    vs[i] = 1'b0;
    sc[i] = s;
    tick();
    tick();
    vs[i] = 1'b1;
    tick();
  endtask

  task automatic pulse_sr(input int i);
    sr[i] = 1'b1;
    tick();
    sr[i] = 1'b0;
  endtask

  task automatic lit(input string nm, input int act,
                     input int req);
    @(negedge clk);
    cmp(nm, act, req);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0;
      vs[i] = 1'b1;
      sc[i] = 1'b0;
      sr[i] = 1'b0;
    end
    tick();
    tick();
    rst_n = 1'b1;
    lit("rst_addr", int'(o_addr[0]), 0);
    cmp("rst_valid", int'(o_val[0]), 0);
    cmp("rst_bank", int'(o_bank[0]), 0);

    frame_start(0, 1'b0);
    run_en(0, 320);
    lit("x1_320", int'(o_addr[0]), 320);
    cmp("x1_valid", int'(o_val[0]), 1);
    run_en(0, 180);
    lit("x1_500", int'(o_addr[0]), 500);

    vs[0] = 1'b0;
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    lit("abort_addr", int'(o_addr[0]), 0);
    cmp("abort_valid", int'(o_val[0]), 0);
    vs[0] = 1'b1;
    tick();

    frame_start(0, 1'b1);
    run_en(0, 2);
    lit("x2_2", int'(o_addr[0]), 1);
    run_en(0, 638);
    lit("x2_640", int'(o_addr[0]), 0);
    run_en(0, 640);
    lit("x2_1280", int'(o_addr[0]), 320);
    run_gap(0, 20);

    pulse_sr(0);
    tick();
    vs[0] = 1'b0;
    sc[0] = 1'b0;
    tick();
    lit("swap_ack", int'(o_ack[0]), 1);
    cmp("swap_bank", int'(o_bank[0]), 1);
    cmp("swap_base", int'(o_addr[0]), 76800);
    tick();
    lit("ack_pulse", int'(o_ack[0]), 0);
    vs[0] = 1'b1;
    tick();
    lit("b1_first", int'(o_addr[0]), 76800);
    run_en(0, 5);
    lit("b1_5", int'(o_addr[0]), 76805);

    pulse_sr(0);
    pulse_sr(0);
    vs[0] = 1'b0;
    tick();
    lit("swap_back", int'(o_bank[0]), 0);
    vs[0] = 1'b1;
    tick();
    tick();

    pulse_sr(0);
    frame_start(0, 1'b0);
    run_en(0, 100);
    lit("b1_100", int'(o_addr[0]), 76900);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    lit("mid_rst_bank", int'(o_bank[0]), 0);
    cmp("mid_rst_addr", int'(o_addr[0]), 0);
    cmp("mid_rst_valid", int'(o_val[0]), 0);

    pulse_sr(1);
    frame_start(1, 1'b0);
    lit("nb1_bank", int'(o_bank[1]), 0);
    run_en(1, 7);
    lit("nb1_7", int'(o_addr[1]), 7);
    cmp("nb1_valid", int'(o_val[1]), 1);
    run_en(1, 1);
    lit("nb1_done", int'(o_fd[1]), 1);
    cmp("nb1_hold", int'(o_addr[1]), 7);
    cmp("nb1_inval", int'(o_val[1]), 0);
    tick();
    lit("nb1_done_1cyc", int'(o_fd[1]), 0);
    run_en(1, 3);
    lit("nb1_ign", int'(o_addr[1]), 7);
    frame_start(1, 1'b1);
    run_en(1, 31);
    lit("nb1_x2_31", int'(o_addr[1]), 7);
    run_en(1, 1);
    lit("nb1_x2_done", int'(o_fd[1]), 1);

    vs[2] = 1'b0;
    sr[2] = 1'b1;
    tick();
    sr[2] = 1'b0;
    lit("nb3_bank1", int'(o_bank[2]), 1);
    tick();
    vs[2] = 1'b1;
    tick();
    run_en(2, 15);
    lit("nb3_done", int'(o_fd[2]), 1);
    cmp("nb3_last", int'(o_addr[2]), 29);
    pulse_sr(2);
    frame_start(2, 1'b1);
    run_en(2, 60);
    lit("nb3_x2_last", int'(o_addr[2]), 44);
    pulse_sr(2);
    frame_start(2, 1'b0);
    lit("nb3_wrap", int'(o_bank[2]), 0);
    cmp("nb3_wrap_addr", int'(o_addr[2]), 0);
    run_en(2, 4);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_addr_gen.md
Name: frame_addr_gen

Overview:
Parametrised successor to the single-frame 320x240 read-address counter. Generates frame-buffer addresses for a configurable H_ACT x V_ACT frame with optional 2x pixel/line replication, so a 320x240 buffer can feed a 640x480 display. Double-buffered: NUM_BANKS banks with a vsync-aligned bank swap handshake. Sits between the VGA timing generator (enable, vsync) and the frame-buffer RAM read port.

Parameters:
H_ACT, 320, source pixels per line
V_ACT, 240, source lines per frame
NUM_BANKS, 2, frame banks in RAM (1 = single buffer, swap disabled)
ADDR_W, 18, address width; must satisfy 2^ADDR_W >= NUM_BANKS*H_ACT*V_ACT (elaboration-time check)

Ports:
CLK25  in  1  pixel clock, 25 MHz
rst_n  in  1  synchronous active-low reset
enable  in  1  display active-video strobe; one pixel consumed per high cycle
vsync  in  1  active-low vertical sync; low = restart frame
scale_2x  in  1  0 = 1:1 read, 1 = each pixel and line repeated twice; sampled only on vsync falling edge
swap_req  in  1  pulse: request bank switch at next frame boundary
address  out  ADDR_W  registered RAM read address
addr_valid  out  1  high while address points inside the current frame (RUN state)
frame_done  out  1  one-cycle pulse when last pixel of a frame is consumed
active_bank  out  $clog2(NUM_BANKS) (min 1)  bank currently being read
swap_ack  out  1  one-cycle pulse when a requested swap takes effect

Behaviour:
- Reset (rst_n=0 at CLK25 edge): state WAIT_VS, address=0, addr_valid=0, frame_done=0, active_bank=0, swap_ack=0, swap pending cleared, internal x/y/sub counters 0, latched mode=1x. Reset mid-frame aborts immediately.
- States: WAIT_VS -> RUN when vsync=1; RUN -> DONE when last pixel consumed; any state -> WAIT_VS when vsync=0.
- vsync=0 has priority over enable in the same cycle: counters clear, address = bank base, addr_valid=0.
- Vsync falling edge (registered vsync_d=1, vsync=0): latch scale_2x; if swap pending (or swap_req high this cycle) and NUM_BANKS>1, active_bank <= (active_bank+1) mod NUM_BANKS, swap_ack pulses the next cycle, pending cleared.
- swap_req outside a falling edge sets pending; repeated requests before the edge collapse to one swap. NUM_BANKS=1: swap_req ignored, swap_ack never pulses.
- Bank base = active_bank*H_ACT*V_ACT, kept as a register updated incrementally; no multiplier in the address path.
- RUN, 1x: each enable advances x; at x=H_ACT-1, x wraps to 0 and line base += H_ACT. address = bank base + line base + x, updated the cycle after enable (1-cycle latency).
- RUN, 2x: x_sub toggles every enable; x advances only when x_sub=1. At end of source line (x=H_ACT-1, x_sub=1), y_sub toggles: y_sub=0 -> replay the line (line base unchanged); y_sub=1 -> line base += H_ACT.
- Last pixel: 1x after H_ACT*V_ACT enables, 2x after 4*H_ACT*V_ACT enables. frame_done pulses for one cycle, state DONE, addr_valid=0, address holds the last valid address (no wrap, no overrun into the next bank).
- enable in WAIT_VS or DONE is ignored.

Decomposition:
- Package frame_addr_pkg: state enum (WAIT_VS, RUN, DONE), default H_ACT/V_ACT constants, mode encoding constants.
- Sub-module fb_bank_ctrl: vsync edge detect, swap pending/ack, active_bank and bank-base register. The top level holds the FSM and x/y/sub counters.

Test Plan:
- 1x, defaults, bank 0: vsync high, 320 enables -> address=320; 76799 enables -> address=76799, addr_valid=1; 76800th enable -> frame_done pulse, addr_valid=0, address stays 76799.
- 2x: 2 enables -> address=1; 640 enables -> address=0 (line replay); 1280 enables -> address=320; 307200 enables -> frame_done.
- Swap: swap_req pulse mid-frame, then vsync falling -> active_bank=1, swap_ack pulse; after vsync rises, first address=76800; next swap returns to bank 0.
- vsync=0 and enable=1 in the same cycle mid-frame (address=500) -> next cycle address=bank base, state WAIT_VS.
- rst_n=0 for one cycle mid-frame with bank 1 active -> all outputs at reset values, active_bank=0.
- NUM_BANKS=1, H_ACT=4, V_ACT=2: swap_req ignored; 8 enables -> frame_done, address=7.
